block_sync_ctrl: RTL
====================

# block_sync_ctrl

Lock controller for the 66b block-alignment path. It sequences the header seeker by clearing it, waiting for it to converge, and adopting its candidate offset. It then verifies the candidate against the live header stream and declares or drops block lock. It sits between the header seeker and the downstream block extractor, which consumes `block_offset_o`.

## Interface
Parameters:
- `SEARCH_BEATS`, default 40: `buffer_dv` beats the seeker runs after a clear before its offset is adopted.
- `SETTLE_BEATS`, default 4: beats ignored after an offset load, covering the seeker and extractor pipelines.
- `LOCK_CNT`, default 32: consecutive valid headers required to declare lock.
- `WIN`, default 64: length of the lock-monitor window, in beats.
- `BAD_MAX`, default 16: invalid headers within one window that cause lock loss.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `buffer_dv` in 1: one beat per buffer update. All counters advance only on beats.
- `seek_offset_i` in 7: seeker candidate offset. Legal range 0..66.
- `hdr_i` in 2: header bits at the applied offset, qualified by `buffer_dv`.
- `relock_i` in 1: software request to force a new search. Level or pulse.
- `seeker_rst_o` out 1: clear request to the seeker.
- `block_offset_o` out 7: applied header offset.
- `offset_ld_o` out 1: one-cycle pulse when `block_offset_o` is loaded.
- `block_lock_o` out 1: block lock status.
- `lock_loss_cnt_o` out 8: count of lock losses, saturating at 255.
- `state_o` out 2: current FSM state.

## Operation
- A header is valid when `hdr_i` is 2'b01 (data) or 2'b10 (cmd). 2'b00 and 2'b11 are invalid.
- The FSM has four states: SEARCH=0, SETTLE=1, CHECK=2, LOCKED=3.
- SEARCH:
  - `beat_cnt` increments per beat.
  - On the beat where `beat_cnt` reaches `SEARCH_BEATS`, if `seek_offset_i` ≤ 66: latch it into `block_offset_o`, pulse `offset_ld_o`, and go to SETTLE.
  - If `seek_offset_i` > 66: stay in SEARCH, clear `beat_cnt`, and pulse `seeker_rst_o`.
- SETTLE: after `SETTLE_BEATS` beats, go to CHECK with `good_cnt`=0. `hdr_i` is ignored in this state.
- CHECK:
  - A valid header increments `good_cnt`. On the `LOCK_CNT`-th valid header, go to LOCKED and set `block_lock_o`=1.
  - Any invalid header returns the FSM to SEARCH (this is a re-search).
- LOCKED:
  - `win_cnt` counts beats and `bad_cnt` counts invalid headers.
  - When `bad_cnt` reaches `BAD_MAX`, this is a lock loss: `block_lock_o`=0, `lock_loss_cnt_o` increments (saturating), and the FSM returns to SEARCH (re-search).
  - When `win_cnt` reaches `WIN` without a loss, clear both `win_cnt` and `bad_cnt`.
  - If the loss condition and the window end fall on the same beat, the loss wins.
- Re-search: `seeker_rst_o` pulses for exactly one cycle, `beat_cnt` clears, and `block_offset_o` holds its previous value.
- `relock_i` high:
  - Takes priority over all other conditions, from any state. The FSM goes to SEARCH and a re-search is performed.
  - `block_lock_o` goes to 0.
  - `lock_loss_cnt_o` does not increment.
  - While `relock_i` stays high, `seeker_rst_o` stays high and the FSM is held in SEARCH.
- Beats with `buffer_dv`=0 change no counter and cause no transition.
- Counter widths are `$clog2(max+1)`. No counter wraps. `lock_loss_cnt_o` holds at 255.

## Timing
- All outputs are registered.
- Reset values:
  - `state_o`=SEARCH
  - `block_offset_o`=0
  - `offset_ld_o`=0
  - `block_lock_o`=0
  - `lock_loss_cnt_o`=0
  - `seeker_rst_o`=1 while `rst_i` is high, then 0 on the first cycle after release.
- Reset asserted mid-operation immediately forces the reset values; all counters clear.
- State transitions, `offset_ld_o`, `seeker_rst_o`, and `block_lock_o` change on the clock edge that samples the qualifying beat, so they are visible one cycle later.
- Best-case time from reset release to `block_lock_o`=1 is `SEARCH_BEATS` + `SETTLE_BEATS` + `LOCK_CNT` beats (76 with default parameters), plus 1 cycle.
- `relock_i` sampled high produces `block_lock_o`=0 and `seeker_rst_o`=1 on the next cycle.
- `offset_ld_o` is never high on the same cycle as `seeker_rst_o`.

## Structure
- Shared package `blk_sync_pkg`:
  - state enum `blk_sync_state_t`
  - constants `C_DATA_HDR`=2'b01, `C_CMD_HDR`=2'b10, `C_MAX_OFFSET`=66
  - function `hdr_valid()`
- Sub-module `blk_lock_window`: contains the `WIN`/`BAD_MAX` monitor.
  - Inputs: enable, beat, bad, clear.
  - Output: a loss pulse.
  - Parameters: `WIN` and `BAD_MAX`.
- All remaining logic lives in the top FSM.

## Test plan
- Clean acquire: seeker offset fixed at 17 and all headers 01/10 → `offset_ld_o` pulse with `block_offset_o`=17 at beat 40, `block_lock_o`=1 after beat 76; `lock_loss_cnt_o`=0.
- CHECK failure: a 2'b11 header on the 10th CHECK beat → FSM returns to SEARCH, one-cycle `seeker_rst_o` pulse, `block_offset_o` stays 17, no lock.
- Lock loss: 16 invalid headers within one 64-beat window while LOCKED → `block_lock_o`=0, `lock_loss_cnt_o`=1, FSM back in SEARCH. With 15 invalid headers per window, lock is held across 4 windows.
- Boundary: 16th invalid header on beat 64 of a window → lock loss occurs. Then drive 300 lock-loss events → `lock_loss_cnt_o` saturates at 255.
- Relock and illegal offset: `relock_i` pulsed while LOCKED → next cycle `block_lock_o`=0, `state_o`=0, `lock_loss_cnt_o` unchanged. `seek_offset_i`=80 at beat 40 → no `offset_ld_o`, `seeker_rst_o` pulse.
- Async reset asserted mid-CHECK with `buffer_dv` idle → all outputs return to their reset values before the next clock edge.

Source files
------------

// File: rtl/block_sync_ctrl_pkg.sv
// Shared types, constants and header helper for the 66b block-sync lock controller.
package blk_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } blk_sync_state_t;

    localparam logic [1:0] C_DATA_HDR     = 2'b01;
    localparam logic [1:0] C_CMD_HDR      = 2'b10;
    localparam logic [6:0] C_MAX_OFFSET   = 7'd66;
    localparam logic [7:0] C_LOSS_CNT_MAX = 8'd255;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == C_DATA_HDR) || (hdr == C_CMD_HDR);
    endfunction

endpackage

// File: rtl/block_sync_ctrl_lock_window.sv
// Lock monitor: counts beats and invalid headers per window, pulses loss when too many are bad.
module blk_lock_window #(
    parameter int WIN     = 64,
    parameter int BAD_MAX = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable,
    input  logic beat,
    input  logic bad,
    input  logic clear,
    output logic loss
);

    localparam int WW = $clog2(WIN + 1);
    localparam int BW = $clog2(BAD_MAX + 1);

    logic [WW-1:0] win_cnt_r;
    logic [WW-1:0] win_cnt_n_s;
    logic [BW-1:0] bad_cnt_r;
    logic [BW-1:0] bad_cnt_n_s;
    logic          loss_s;
    logic          win_end_s;

    // Loss takes precedence over window end; both restart the window.
    always_comb begin
        loss_s      = enable && beat && bad && (bad_cnt_r == BW'(BAD_MAX - 1));
        win_end_s   = enable && beat && (win_cnt_r == WW'(WIN - 1));
        win_cnt_n_s = win_cnt_r;
        bad_cnt_n_s = bad_cnt_r;
        if (clear || !enable) begin
            win_cnt_n_s = '0;
            bad_cnt_n_s = '0;
        end else if (beat) begin
            if (loss_s || win_end_s) begin
                win_cnt_n_s = '0;
                bad_cnt_n_s = '0;
            end else begin
                win_cnt_n_s = win_cnt_r + WW'(1);
                bad_cnt_n_s = bad_cnt_r + BW'(bad);
            end
        end else begin
            win_cnt_n_s = win_cnt_r;
            bad_cnt_n_s = bad_cnt_r;
        end
    end

    // Window counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_cnt_r <= '0;
            bad_cnt_r <= '0;
        end else begin
            win_cnt_r <= win_cnt_n_s;
            bad_cnt_r <= bad_cnt_n_s;
        end
    end

    assign loss = loss_s;

endmodule

// File: rtl/block_sync_ctrl.sv
// Block lock controller: sequences the header seeker, adopts its offset, and declares/drops lock.
module block_sync_ctrl
    import blk_sync_pkg::*;
#(
    parameter int SEARCH_BEATS = 40,
    parameter int SETTLE_BEATS = 4,
    parameter int LOCK_CNT     = 32,
    parameter int WIN          = 64,
    parameter int BAD_MAX      = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       buffer_dv,
    input  logic [6:0] seek_offset_i,
    input  logic [1:0] hdr_i,
    input  logic       relock_i,
    output logic       seeker_rst_o,
    output logic [6:0] block_offset_o,
    output logic       offset_ld_o,
    output logic       block_lock_o,
    output logic [7:0] lock_loss_cnt_o,
    output logic [1:0] state_o
);

    localparam int BEAT_MAX = (SEARCH_BEATS > SETTLE_BEATS) ? SEARCH_BEATS : SETTLE_BEATS;
    localparam int BCW      = $clog2(BEAT_MAX + 1);
    localparam int GCW      = $clog2(LOCK_CNT + 1);

    blk_sync_state_t state_r;
    blk_sync_state_t state_n_s;

    logic [BCW-1:0] beat_cnt_r;
    logic [BCW-1:0] beat_cnt_n_s;
    logic [GCW-1:0] good_cnt_r;
    logic [GCW-1:0] good_cnt_n_s;
    logic [6:0]     offset_r;
    logic [6:0]     offset_n_s;
    logic           offset_ld_r;
    logic           offset_ld_n_s;
    logic           seeker_rst_r;
    logic           seeker_rst_n_s;
    logic           block_lock_r;
    logic           block_lock_n_s;
    logic [7:0]     loss_cnt_r;
    logic [7:0]     loss_cnt_n_s;

    logic hdr_ok_s;
    logic load_s;
    logic research_s;
    logic lock_set_s;
    logic loss_ev_s;
    logic win_loss_s;
    logic win_en_s;

    assign hdr_ok_s = hdr_valid(hdr_i);
    assign win_en_s = (state_r == LOCKED);

    blk_lock_window #(
        .WIN     (WIN),
        .BAD_MAX (BAD_MAX)
    ) u_lock_window (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable  (win_en_s),
        .beat    (buffer_dv),
        .bad     (!hdr_ok_s),
        .clear   (relock_i),
        .loss    (win_loss_s)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= SEARCH;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic; relock overrides everything, otherwise only beats advance the FSM.
    always_comb begin
        state_n_s  = state_r;
        load_s     = 1'b0;
        research_s = 1'b0;
        lock_set_s = 1'b0;
        loss_ev_s  = 1'b0;
        if (relock_i) begin
            state_n_s  = SEARCH;
            research_s = 1'b1;
        end else if (buffer_dv) begin
            case (state_r)
                SEARCH: begin
                    if (beat_cnt_r == BCW'(SEARCH_BEATS - 1)) begin
                        if (seek_offset_i <= C_MAX_OFFSET) begin
                            state_n_s = SETTLE;
                            load_s    = 1'b1;
                        end else begin
                            research_s = 1'b1;
                        end
                    end else begin
                        state_n_s = SEARCH;
                    end
                end
                SETTLE: begin
                    if (beat_cnt_r == BCW'(SETTLE_BEATS - 1)) begin
                        state_n_s = CHECK;
                    end else begin
                        state_n_s = SETTLE;
                    end
                end
                CHECK: begin
                    if (!hdr_ok_s) begin
                        state_n_s  = SEARCH;
                        research_s = 1'b1;
                    end else if (good_cnt_r == GCW'(LOCK_CNT - 1)) begin
                        state_n_s  = LOCKED;
                        lock_set_s = 1'b1;
                    end else begin
                        state_n_s = CHECK;
                    end
                end
                LOCKED: begin
                    if (win_loss_s) begin
                        state_n_s  = SEARCH;
                        research_s = 1'b1;
                        loss_ev_s  = 1'b1;
                    end else begin
                        state_n_s = LOCKED;
                    end
                end
                default: begin
                    state_n_s  = SEARCH;
                    research_s = 1'b1;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Output and counter next values; counters restart on every state change.
    always_comb begin
        offset_ld_n_s  = load_s;
        seeker_rst_n_s = research_s;
        block_lock_n_s = lock_set_s || (block_lock_r && !research_s);
        offset_n_s     = load_s ? seek_offset_i : offset_r;
        if (loss_ev_s && (loss_cnt_r != C_LOSS_CNT_MAX)) begin
            loss_cnt_n_s = loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_n_s = loss_cnt_r;
        end
        if (research_s || (state_n_s != state_r)) begin
            beat_cnt_n_s = '0;
        end else if (buffer_dv && ((state_r == SEARCH) || (state_r == SETTLE))) begin
            beat_cnt_n_s = beat_cnt_r + BCW'(1);
        end else begin
            beat_cnt_n_s = beat_cnt_r;
        end
        if ((state_r != CHECK) || (state_n_s != CHECK)) begin
            good_cnt_n_s = '0;
        end else if (buffer_dv && hdr_ok_s) begin
            good_cnt_n_s = good_cnt_r + GCW'(1);
        end else begin
            good_cnt_n_s = good_cnt_r;
        end
    end

    // Registered outputs and counters; seeker clear is asserted throughout reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_r   <= '0;
            good_cnt_r   <= '0;
            offset_r     <= 7'd0;
            offset_ld_r  <= 1'b0;
            seeker_rst_r <= 1'b1;
            block_lock_r <= 1'b0;
            loss_cnt_r   <= 8'd0;
        end else begin
            beat_cnt_r   <= beat_cnt_n_s;
            good_cnt_r   <= good_cnt_n_s;
            offset_r     <= offset_n_s;
            offset_ld_r  <= offset_ld_n_s;
            seeker_rst_r <= seeker_rst_n_s;
            block_lock_r <= block_lock_n_s;
            loss_cnt_r   <= loss_cnt_n_s;
        end
    end

    assign seeker_rst_o    = seeker_rst_r;
    assign block_offset_o  = offset_r;
    assign offset_ld_o     = offset_ld_r;
    assign block_lock_o    = block_lock_r;
    assign lock_loss_cnt_o = loss_cnt_r;
    assign state_o         = state_r;

endmodule
